// File: rtl/serial_paralelo_sync_ctrl.sv
// Receive-side sequencer for the serial-to-parallel lane. It hunts for the comma symbol,
// locks byte alignment after SYNC_COUNT aligned commas, then strobes out one byte per 8 bits.
module serial_paralelo_sync_ctrl #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       resync,
    output logic [7:0] data_out,
    output logic       byte_strobe,
    output logic       valid_out,
    output logic       active,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

    state_t     state, state_nx;
    logic [7:0] sr, sr_nx, data_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [3:0] bc_cnt, bc_cnt_nx, bc_inc;
    logic       strobe_nx, valid_nx, active_nx, boundary;

    // The byte is judged on sr_nx so that outputs update on the edge shifting in its last bit.
    assign sr_nx     = {sr[6:0], data_in};
    assign boundary  = (bit_cnt == 3'd7);
    assign bc_inc    = bc_cnt + 4'd1;
    assign state_out = state;

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path leaves a latch behind.
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        bc_cnt_nx  = bc_cnt;
        data_nx    = data_out;
        strobe_nx  = 1'b0;
        valid_nx   = valid_out;
        active_nx  = active;

        if (resync) begin
            state_nx   = HUNT;
            bit_cnt_nx = 3'd0;
            bc_cnt_nx  = 4'd0;
            valid_nx   = 1'b0;
            active_nx  = 1'b0;
        end else begin
            unique case (state)
                HUNT: begin
                    if (sr_nx == COMMA) begin
                        bit_cnt_nx = 3'd0;
                        bc_cnt_nx  = 4'd1;
                        if (SYNC_COUNT == 1) begin
                            state_nx  = ACTIVE;
                            active_nx = 1'b1;
                        end else begin
                            state_nx  = ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (boundary) begin
                        if (sr_nx == COMMA) begin
                            bc_cnt_nx = bc_inc;
                            if (bc_inc == SYNC_TARGET) begin
                                state_nx  = ACTIVE;
                                active_nx = 1'b1;
                            end
                        end else begin
                            // Hunting resumes next edge on the retained shift register.
                            state_nx  = HUNT;
                            bc_cnt_nx = 4'd0;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (boundary) begin
                        data_nx   = sr_nx;
                        strobe_nx = 1'b1;
                        valid_nx  = (sr_nx != COMMA);
                    end
                end
                default: begin
                    state_nx = HUNT;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state       <= HUNT;
            sr          <= 8'd0;
            bit_cnt     <= 3'd0;
            bc_cnt      <= 4'd0;
            data_out    <= 8'd0;
            byte_strobe <= 1'b0;
            valid_out   <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_nx;
            sr          <= sr_nx;
            bit_cnt     <= bit_cnt_nx;
            bc_cnt      <= bc_cnt_nx;
            data_out    <= data_nx;
            byte_strobe <= strobe_nx;
            valid_out   <= valid_nx;
            active      <= active_nx;
        end
    end

endmodule

// File: tb/tb_serial_paralelo_sync_ctrl.sv
// Bench for serial_paralelo_sync_ctrl: scoreboard of expected strobed bytes on the SYNC_COUNT=4
// lane, plus a second SYNC_COUNT=1 instance for the single-comma lock case.
module tb_serial_paralelo_sync_ctrl;

    localparam logic [7:0] COMMA = 8'hBC;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       data_in, resync;
    logic [7:0] data_out;
    logic       byte_strobe, valid_out, active;
    logic [1:0] state_out;

    logic       data_in1;
    logic       resync1;
    logic [7:0] data_out1;
    logic       byte_strobe1, valid_out1, active1;
    logic [1:0] state_out1;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc = 0;
    int   last_strobe = -1;

    serial_paralelo_sync_ctrl #(.COMMA(COMMA), .SYNC_COUNT(4)) dut (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .resync(resync),
        .data_out(data_out), .byte_strobe(byte_strobe), .valid_out(valid_out),
        .active(active), .state_out(state_out)
    );

    serial_paralelo_sync_ctrl #(.COMMA(COMMA), .SYNC_COUNT(1)) dut1 (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in1), .resync(resync1),
        .data_out(data_out1), .byte_strobe(byte_strobe1), .valid_out(valid_out1),
        .active(active1), .state_out(state_out1)
    );

    always #5 clk_32f = ~clk_32f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor for the SYNC_COUNT=4 lane.
    always @(posedge clk_32f) begin
        exp_t e;
        #1;
        cyc++;
        if (!active) last_strobe = -1;
        if (byte_strobe) begin
            vectors++;
            if (!active) begin
                errors++;
                $display("FAIL strobe_without_active: active=%b required 1", active);
            end
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: data_out=%h valid=%b, none expected", data_out, valid_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e.data || valid_out !== e.valid) begin
                    errors++;
                    $display("FAIL strobe_data: got %h/%b required %h/%b", data_out, valid_out, e.data, e.valid);
                end
            end
            if (last_strobe >= 0) begin
                vectors++;
                if (cyc - last_strobe != 8) begin
                    errors++;
                    $display("FAIL strobe_spacing: got %0d cycles required 8", cyc - last_strobe);
                end
            end
            last_strobe = cyc;
        end
    end

    task automatic send_bit(input logic b, input bit lane);
        if (lane) data_in1 = b;
        else      data_in  = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit lane);
        for (int i = 7; i >= 0; i--) send_bit(b[i], lane);
    endtask

    task automatic send_data(input logic [7:0] b);
        exp_q.push_back('{data: b, valid: (b != COMMA)});
        send_byte(b, 1'b0);
    endtask

    task automatic expect_lane(input string name, input logic [1:0] st, input logic act);
        vectors++;
        if (state_out !== st || active !== act) begin
            errors++;
            $display("FAIL %s: state=%0d active=%b required state=%0d active=%b",
                     name, state_out, active, st, act);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; data_in = 1'b0; data_in1 = 1'b0; resync = 1'b0; resync1 = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        vectors++;
        if ({data_out, byte_strobe, valid_out, active, state_out} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b/%0d required all 0",
                     data_out, byte_strobe, valid_out, active, state_out);
        end
        vectors++;
        if (active1 !== 1'b0 || state_out1 !== 2'd0) begin
            errors++;
            $display("FAIL reset_lane1: active=%b state=%0d required 0/0", active1, state_out1);
        end
        reset = 1'b1;
    endtask

    task automatic test_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        expect_lane("hunt_before_comma", 2'd0, 1'b0);
        send_byte(COMMA, 1'b0);
        expect_lane("align_after_bc1", 2'd1, 1'b0);
        send_byte(COMMA, 1'b0);
        send_byte(COMMA, 1'b0);
        expect_lane("align_after_bc3", 2'd1, 1'b0);
        send_byte(COMMA, 1'b0);
        expect_lane("active_after_bc4", 2'd2, 1'b1);
        vectors++;
        if (byte_strobe !== 1'b0) begin
            errors++;
            $display("FAIL no_strobe_on_lock: byte_strobe=%b required 0", byte_strobe);
        end
        send_data(8'hFF);
        send_data(8'hEE);
    endtask

    task automatic test_idle();
        send_data(COMMA);
        expect_lane("active_after_idle", 2'd2, 1'b1);
    endtask

    task automatic test_resync();
        logic [7:0] b;
        b = 8'h3C;
        for (int i = 7; i > 0; i--) send_bit(b[i], 1'b0);
        resync = 1'b1;
        send_bit(b[0], 1'b0);
        resync = 1'b0;
        expect_lane("resync_to_hunt", 2'd0, 1'b0);
        vectors++;
        if (byte_strobe !== 1'b0 || data_out !== COMMA || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL resync_outputs: got %b/%h/%b required 0/%h/0",
                     byte_strobe, data_out, valid_out, COMMA);
        end
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(COMMA, 1'b0);
        expect_lane("realign_bc3", 2'd1, 1'b0);
        send_byte(COMMA, 1'b0);
        expect_lane("realign_bc4", 2'd2, 1'b1);
        send_data(8'h5A);
    endtask

    task automatic test_align_break();
        resync = 1'b1;
        send_bit(1'b0, 1'b0);
        resync = 1'b0;
        send_byte(8'h00, 1'b0);
        expect_lane("hunt_after_resync", 2'd0, 1'b0);
        send_byte(COMMA, 1'b0);
        expect_lane("break_align_bc1", 2'd1, 1'b0);
        send_byte(COMMA, 1'b0);
        send_byte(8'h55, 1'b0);
        expect_lane("break_back_to_hunt", 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(COMMA, 1'b0);
        expect_lane("fresh_bc3", 2'd1, 1'b0);
        send_byte(COMMA, 1'b0);
        expect_lane("fresh_bc4", 2'd2, 1'b1);
    endtask

    task automatic test_async_reset();
        send_data(8'hC3);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({data_out, byte_strobe, valid_out, active, state_out} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got %h/%b/%b/%b/%0d required all 0",
                     data_out, byte_strobe, valid_out, active, state_out);
        end
        data_in = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(COMMA, 1'b0);
        expect_lane("post_reset_bc3", 2'd1, 1'b0);
        send_byte(COMMA, 1'b0);
        expect_lane("post_reset_bc4", 2'd2, 1'b1);
        send_data(8'h81);
    endtask

    task automatic test_single_comma();
        logic [7:0] b;
        b = 8'hA5;
        resync = 1'b1;
        send_byte(COMMA, 1'b1);
        vectors++;
        if (active1 !== 1'b1 || state_out1 !== 2'd2 || byte_strobe1 !== 1'b0) begin
            errors++;
            $display("FAIL sc1_lock: active=%b state=%0d strobe=%b required 1/2/0",
                     active1, state_out1, byte_strobe1);
        end
        for (int i = 7; i > 0; i--) send_bit(b[i], 1'b1);
        vectors++;
        if (byte_strobe1 !== 1'b0) begin
            errors++;
            $display("FAIL sc1_early_strobe: strobe=%b required 0", byte_strobe1);
        end
        send_bit(b[0], 1'b1);
        vectors++;
        if (byte_strobe1 !== 1'b1 || data_out1 !== 8'hA5 || valid_out1 !== 1'b1) begin
            errors++;
            $display("FAIL sc1_data: got %b/%h/%b required 1/a5/1", byte_strobe1, data_out1, valid_out1);
        end
        send_bit(1'b0, 1'b1);
        vectors++;
        if (byte_strobe1 !== 1'b0 || valid_out1 !== 1'b1) begin
            errors++;
            $display("FAIL sc1_pulse: strobe=%b valid=%b required 0/1", byte_strobe1, valid_out1);
        end
        resync = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sync();
        test_idle();
        test_resync();
        test_align_break();
        test_async_reset();
        test_single_comma();
        repeat (2) @(posedge clk_32f);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: %0d expected bytes never strobed", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
